// File: rtl/csr_exec_unit.sv
// Execute-stage CSR/trap controller: Zicsr read-modify-write, ECALL trap entry and MRET return,
// driving the single read and single write port of the downstream CSR register file.
module csr_exec_unit #(
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic [11:0] in_csr_addr,
    input  logic [4:0]  in_rs1_idx,
    input  logic [31:0] in_rs1_data,
    input  logic [4:0]  in_rd_idx,
    input  logic [31:0] in_pc,
    input  logic        in_is_ecall,
    input  logic        in_is_mret,
    output logic [11:0] csr_addr_r,
    input  logic [31:0] csr_data_r,
    output logic [11:0] csr_addr_w,
    output logic [31:0] csr_data_w,
    output logic        csr_we,
    output logic        out_valid,
    output logic [4:0]  out_rd_idx,
    output logic [31:0] out_rd_data,
    output logic        out_rd_we,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        illegal
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        TRAP_CAUSE = 2'd1,
        TRAP_JUMP  = 2'd2,
        MRET_RD    = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        accept_s;
    logic        op_ecall_s;
    logic        op_mret_s;
    logic        op_csr_s;
    logic        op_illegal_s;
    logic        csr_write_s;
    logic        csr_we_s;
    logic [31:0] src_s;
    logic [31:0] new_s;

    // Zicsr update rule selected by funct3[1:0]: 01 write, 10 set bits, 11 clear bits.
    function automatic logic [31:0] csr_rmw(input logic [1:0] op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] src_val);
        logic [31:0] res;
        case (op)
            2'b01:   res = src_val;
            2'b10:   res = old_val | src_val;
            2'b11:   res = old_val & ~src_val;
            default: res = old_val;
        endcase
        return res;
    endfunction

    // Instruction decode with ECALL > MRET > funct3 priority.
    always_comb begin
        accept_s     = in_valid && (state_r == IDLE);
        op_ecall_s   = accept_s && in_is_ecall;
        op_mret_s    = accept_s && !in_is_ecall && in_is_mret;
        op_csr_s     = accept_s && !in_is_ecall && !in_is_mret && (in_funct3[1:0] != 2'b00);
        op_illegal_s = accept_s && !in_is_ecall && !in_is_mret && (in_funct3[1:0] == 2'b00);
        src_s        = in_funct3[2] ? {27'd0, in_rs1_idx} : in_rs1_data;
        new_s        = csr_rmw(in_funct3[1:0], csr_data_r, src_s);
        // Set/clear with a zero source must not touch the CSR (side-effect free read).
        csr_write_s  = (in_funct3[1:0] == 2'b01) || (in_rs1_idx != 5'd0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (op_ecall_s) begin
                    state_next_s = TRAP_CAUSE;
                end else if (op_mret_s) begin
                    state_next_s = MRET_RD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            TRAP_CAUSE: state_next_s = TRAP_JUMP;
            TRAP_JUMP:  state_next_s = IDLE;
            MRET_RD:    state_next_s = IDLE;
            default:    state_next_s = IDLE;
        endcase
    end

    // CSR port and handshake outputs.
    always_comb begin
        in_ready   = 1'b0;
        csr_addr_r = in_csr_addr;
        csr_addr_w = in_csr_addr;
        csr_data_w = new_s;
        csr_we_s   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (op_ecall_s) begin
                    csr_we_s   = 1'b1;
                    csr_addr_w = MEPC_ADDR;
                    csr_data_w = in_pc;
                end else if (op_csr_s) begin
                    csr_we_s = csr_write_s;
                end else begin
                    csr_we_s = 1'b0;
                end
            end
            TRAP_CAUSE: begin
                csr_we_s   = 1'b1;
                csr_addr_w = MCAUSE_ADDR;
                csr_data_w = ECALL_CAUSE;
            end
            TRAP_JUMP: csr_addr_r = MTVEC_ADDR;
            MRET_RD:   csr_addr_r = MEPC_ADDR;
            default:   csr_we_s = 1'b0;
        endcase
    end

    // Reset must block any write even though the FSM decode is still live.
    assign csr_we = csr_we_s & rst_n;

    // Registered writeback and redirect pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_rd_idx     <= 5'd0;
            out_rd_data    <= 32'd0;
            out_rd_we      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            illegal        <= 1'b0;
        end else begin
            out_valid      <= op_csr_s || op_illegal_s;
            illegal        <= op_illegal_s;
            out_rd_we      <= op_csr_s && (in_rd_idx != 5'd0);
            redirect_valid <= (state_r == TRAP_JUMP) || (state_r == MRET_RD);
            if (op_csr_s || op_illegal_s) begin
                out_rd_idx  <= in_rd_idx;
                out_rd_data <= csr_data_r;
            end
            if (state_r == TRAP_JUMP) begin
                redirect_pc <= {csr_data_r[31:2], 2'b00};
            end else if (state_r == MRET_RD) begin
                redirect_pc <= {csr_data_r[31:1], 1'b0};
            end
        end
    end

endmodule
